// File: rtl/misr_pkg.sv
// Shared types and helpers for the response MISR checker: FSM states,
// default MISR constants and the chunk XOR fold of a wide sample.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;

  // Widest sample / signature the fold helper accepts.
  localparam int MAX_Y_W   = 1024;
  localparam int MAX_SIG_W = 64;

  // XOR of all sig_w-bit chunks of y; bits at or above y_w must already be zero.
  function automatic logic [MAX_SIG_W-1:0] fold_xor(
    input logic [MAX_Y_W-1:0] y,
    input int                 y_w,
    input int                 sig_w
  );
    logic [MAX_SIG_W-1:0] mask;
    logic [MAX_SIG_W-1:0] acc;
    mask = {MAX_SIG_W{1'b1}} >> (MAX_SIG_W - sig_w);
    acc  = '0;
    for (int k = 0; k < MAX_Y_W; k++) begin
      if (k * sig_w >= y_w) break;
      acc = acc ^ (MAX_SIG_W'(y >> (k * sig_w)) & mask);
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr_step.sv
// One MISR update: shift left, apply polynomial feedback from the MSB,
// and inject the folded sample.
module misr_step #(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C1_1DB7
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [SIG_W-1:0] fold_i,
  output logic [SIG_W-1:0] sig_o
);

  assign sig_o = {sig_i[SIG_W-2:0], 1'b0}
               ^ (sig_i[SIG_W-1] ? POLY : '0)
               ^ fold_i;

endmodule

// File: rtl/response_misr_checker.sv
// Compresses a programmed number of valid DUT output samples into a MISR
// signature and compares it against an expected value.
module response_misr_checker
  import misr_pkg::*;
#(
  parameter int               Y_W       = 350,
  parameter int               SIG_W     = 32,
  parameter logic [SIG_W-1:0] POLY      = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED      = SIG_W'(DEFAULT_SEED),
  parameter int               N_SAMPLES = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_valid,
  input  logic [Y_W-1:0]   y_in,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      sample_cnt
);

  localparam logic [15:0] LAST_CNT = 16'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;

  logic [MAX_Y_W-1:0] y_ext;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   sig_step;

  // Zero-extension supplies the padding of the top partial chunk.
  assign y_ext = MAX_Y_W'(y_in);
  assign fold  = SIG_W'(fold_xor(y_ext, Y_W, SIG_W));

  misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig_i  (sig_q),
    .fold_i (fold),
    .sig_o  (sig_step)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (y_valid) begin
          sig_d = sig_step;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pass_d  = (sig_q == exp_sig);
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_response_misr_checker.sv
// Directed plus randomized checks of response_misr_checker against a
// behavioural signature model; four instances cover different N/SEED values.
module tb_response_misr_checker;

  localparam int          Y_W  = 350;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam int          NS[4] = '{22, 1, 1, 3};
  localparam logic [31:0] SD[4] = '{32'h0, 32'h0, 32'h8000_0000, 32'h0};

  typedef logic [Y_W-1:0] y_t;

  logic        clk = 1'b0;
  logic        rst_n, start, y_valid;
  y_t          y_in;
  logic [31:0] exp_sig;
  logic        busy [4];
  logic        done [4];
  logic        pass [4];
  logic [31:0] sig  [4];
  logic [15:0] cnt  [4];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Index 0: defaults (N=22); 1: N=1 SEED=0; 2: N=1 SEED=8000_0000; 3: N=3 SEED=0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    response_misr_checker #(
      .Y_W       (Y_W),
      .SIG_W     (32),
      .POLY      (POLY),
      .SEED      (SD[gi]),
      .N_SAMPLES (NS[gi])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .y_valid    (y_valid),
      .y_in       (y_in),
      .exp_sig    (exp_sig),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .pass       (pass[gi]),
      .signature  (sig[gi]),
      .sample_cnt (cnt[gi])
    );
  end

  // Behavioural model: fold = XOR of 32-bit chunks, then multiply by x modulo POLY.
  function automatic logic [31:0] fold_ref(input y_t v);
    logic [351:0] w;
    logic [31:0]  r;
    w = {2'b00, v};
    r = '0;
    for (int k = 0; k < 11; k++) r = r ^ w[k*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] misr_ref(input logic [31:0] seed, input y_t q[$]);
    logic [32:0] t;
    logic [31:0] s;
    s = seed;
    foreach (q[i]) begin
      t = {s, 1'b0};
      if (t[32]) t = t ^ {1'b1, POLY};
      s = t[31:0] ^ fold_ref(q[i]);
    end
    return s;
  endfunction

  function automatic y_t rand_y();
    logic [351:0] w;
    for (int k = 0; k < 11; k++) w[k*32 +: 32] = $urandom;
    return w[Y_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    y_valid = 1'b0;
    y_in    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic absorb(input y_t v);
    y_valid = 1'b1;
    y_in    = v;
    tick();
    y_valid = 1'b0;
    y_in    = '0;
  endtask

  task automatic wait_done(input int idx, input int budget, output int edges);
    edges = 0;
    while (!done[idx] && edges < budget) begin
      tick();
      edges++;
    end
    chk($sformatf("done_seen_%0d", idx), 64'(done[idx]), 64'd1);
  endtask

  initial begin
    y_t          q[$];
    y_t          q2[$];
    y_t          v;
    logic [31:0] golden;
    logic [31:0] expv;
    int          e;
    int          si, bi;

    rst_n = 1'b0; start = 1'b0; y_valid = 1'b0; y_in = '0; exp_sig = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_done", 64'(done[0]), 64'd0);
    chk("rst_pass", 64'(pass[0]), 64'd0);
    chk("rst_sig",  64'(sig[0]),  64'd0);
    chk("rst_cnt",  64'(cnt[0]),  64'd0);
    chk("rst_sig_seeded", 64'(sig[2]), 64'h8000_0000);
    rst_n = 1'b1;
    tick();

    // All-zero run, N=1.
    exp_sig = '0;
    start_run();
    chk("zero_busy", 64'(busy[1]), 64'd1);
    absorb('0);
    wait_done(1, 10, e);
    chk("zero_latency", 64'(2 + e), 64'd3);
    chk("zero_pass", 64'(pass[1]), 64'd1);
    chk("zero_sig",  64'(sig[1]),  64'd0);
    chk("zero_idle", 64'(busy[1]), 64'd0);

    // Feedback from the MSB of the seed.
    do_reset();
    start_run();
    absorb('0);
    wait_done(2, 10, e);
    chk("fb_sig",  64'(sig[2]),  64'h04C1_1DB7);
    chk("fb_pass", 64'(pass[2]), 64'd0);

    // Shift: samples 1 then 0.
    do_reset();
    start_run();
    v = '0; v[0] = 1'b1;
    absorb(v);
    chk("shift_sig1", 64'(sig[3]), 64'd1);
    absorb('0);
    chk("shift_sig2", 64'(sig[3]), 64'd2);
    chk("shift_cnt2", 64'(cnt[3]), 64'd2);

    // Fold boundaries.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      v = '0;
      case (i)
        0: begin v[32] = 1'b1; expv = 32'h0000_0001; end
        1: begin v[349] = 1'b1; expv = 32'h2000_0000; end
        default: begin v[0] = 1'b1; v[32] = 1'b1; expv = 32'h0; end
      endcase
      exp_sig = expv;
      start_run();
      absorb(v);
      wait_done(1, 10, e);
      chk($sformatf("fold_sig_%0d", i), 64'(sig[1]), 64'(expv));
      chk($sformatf("fold_pass_%0d", i), 64'(pass[1]), 64'd1);
    end

    // Valid gaps plus a stray start during RUN.
    do_reset();
    q = {};
    start_run();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        v = rand_y();
        q.push_back(v);
        y_valid = 1'b1;
      end else begin
        v = rand_y();
        y_valid = 1'b0;
      end
      y_in  = v;
      start = (i == 1);
      tick();
      chk($sformatf("gap_cnt_%0d", i), 64'(cnt[3]), 64'(i / 2 + 1));
    end
    y_valid = 1'b0; start = 1'b0;
    exp_sig = misr_ref(32'h0, q);
    wait_done(3, 10, e);
    chk("gap_sig",  64'(sig[3]),  64'(misr_ref(32'h0, q)));
    chk("gap_pass", 64'(pass[3]), 64'd1);

    // Golden random run, N=22, with random idle gaps.
    do_reset();
    q = {};
    start_run();
    while (q.size() < 22) begin
      if ($urandom_range(0, 2) != 0) begin
        v = rand_y();
        q.push_back(v);
        absorb(v);
      end else begin
        y_in = rand_y();
        tick();
        y_in = '0;
      end
    end
    golden  = misr_ref(32'h0, q);
    exp_sig = golden;
    wait_done(0, 10, e);
    chk("gold_pass", 64'(pass[0]), 64'd1);
    chk("gold_sig",  64'(sig[0]),  64'(golden));
    chk("gold_cnt",  64'(cnt[0]),  64'd22);

    // Restart in the done cycle; then one flipped bit, y_valid held high.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done_low", 64'(done[0]), 64'd0);
    chk("restart_pass_clr", 64'(pass[0]), 64'd0);
    chk("restart_busy",     64'(busy[0]), 64'd1);
    chk("restart_cnt",      64'(cnt[0]),  64'd0);
    q2 = q;
    si = $urandom_range(0, 21);
    bi = $urandom_range(0, Y_W - 1);
    v = q2[si];
    v[bi] = ~v[bi];
    q2[si] = v;
    foreach (q2[i]) absorb(q2[i]);
    wait_done(0, 10, e);
    chk("bad_latency", 64'(1 + 22 + e), 64'd24);
    chk("bad_pass", 64'(pass[0]), 64'd0);
    chk("bad_sig",  64'(sig[0]),  64'(misr_ref(32'h0, q2)));
    tick();
    chk("bad_done_pulse", 64'(done[0]), 64'd0);
    chk("bad_pass_hold",  64'(pass[0]), 64'd0);

    // Asynchronous reset after 10 of 22 samples, then a clean golden run.
    start_run();
    for (int i = 0; i < 10; i++) absorb(q[i]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_done", 64'(done[0]), 64'd0);
    chk("mid_rst_pass", 64'(pass[0]), 64'd0);
    chk("mid_rst_sig",  64'(sig[0]),  64'd0);
    chk("mid_rst_cnt",  64'(cnt[0]),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_sig = golden;
    start_run();
    foreach (q[i]) absorb(q[i]);
    wait_done(0, 10, e);
    chk("post_rst_pass", 64'(pass[0]), 64'd1);
    chk("post_rst_sig",  64'(sig[0]),  64'(golden));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
